// File: rtl/mem_access_unit.sv
// Load/store unit bridging a controller to a word-wide request/ack bus.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating the address.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  data_length,
   input  logic        load_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] LEN_WORD = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_BYTE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [1:0]  len_q;
   logic        uns_q;
   logic [1:0]  off_q;
   logic        write_q;
   logic        accept;
   logic [1:0]  len_in;
   logic [1:0]  off_in;

   // The reserved size code behaves as a full word everywhere downstream.
   function automatic logic [1:0] norm_len(input logic [1:0] len);
      return (len == 2'b11) ? LEN_WORD : len;
   endfunction

   // Byte offset actually used: low bits a half/word cannot honour are cleared.
   function automatic logic [1:0] eff_off(input logic [1:0] len, input logic [1:0] a);
      case (len)
         LEN_BYTE: return a;
         LEN_HALF: return {a[1], 1'b0};
         default:  return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] calc_be(input logic [1:0] len, input logic [1:0] off);
      case (len)
         LEN_BYTE: return 4'b0001 << off;
         LEN_HALF: return 4'b0011 << {off[1], 1'b0};
         default:  return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] calc_wdata(input logic [1:0] len, input logic [31:0] wd);
      case (len)
         LEN_BYTE: return {4{wd[7:0]}};
         LEN_HALF: return {2{wd[15:0]}};
         default:  return wd;
      endcase
   endfunction

   function automatic logic [31:0] extract_load(input logic [1:0]  len,
                                                input logic        uns,
                                                input logic [1:0]  off,
                                                input logic [31:0] raw);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = raw[7:0];
         2'd1:    b = raw[15:8];
         2'd2:    b = raw[23:16];
         default: b = raw[31:24];
      endcase
      h = off[1] ? raw[31:16] : raw[15:0];
      case (len)
         LEN_BYTE: return {{24{b[7] & ~uns}}, b};
         LEN_HALF: return {{16{h[15] & ~uns}}, h};
         default:  return raw;
      endcase
   endfunction

`ifdef MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [1:0] len, input logic [1:0] a);
      case (len)
         LEN_HALF: return a[0];
         LEN_WORD: return |a;
         default:  return 1'b0;
      endcase
   endfunction
`endif

   assign accept = (state == IDLE) && (mem_read || mem_write);
   assign len_in = norm_len(data_length);
   assign off_in = eff_off(len_in, addr[1:0]);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous; rst is only looked at on the rising edge.
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         len_q     <= LEN_WORD;
         uns_q     <= 1'b0;
         off_q     <= 2'b00;
         write_q   <= 1'b0;
         rdata     <= 32'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         bus_be    <= 4'd0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  // A simultaneous read and write resolves to the store.
                  write_q   <= mem_write;
                  len_q     <= len_in;
                  uns_q     <= load_unsigned;
                  off_q     <= off_in;
                  wait_cnt  <= 4'd0;
                  busy      <= 1'b1;
                  bus_we    <= mem_write;
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_be    <= calc_be(len_in, off_in);
                  bus_wdata <= calc_wdata(len_in, wdata);
`ifdef MISALIGN_TRAP_EN
                  if (misaligned(len_in, addr[1:0])) begin
                     state <= RESP;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state   <= REQ;
                     bus_req <= 1'b1;
                  end
`else
                  state   <= REQ;
                  bus_req <= 1'b1;
`endif
               end
            end

            REQ: begin
               // An ack on the last allowed cycle still counts as success.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  state   <= RESP;
                  if (!write_q) begin
                     rdata <= extract_load(len_q, uns_q, off_q, bus_rdata);
                  end
               end else if (wait_cnt == 4'd15) begin
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  err     <= 1'b1;
                  state   <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end

            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy    <= 1'b0;
               bus_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
